// File: rtl/sound_arb_pkg.sv
// ---------------------------------------------------------------------------
// sound_arb_pkg
// Shared definitions for the piezo sound arbiter: the arbiter state
// encoding, the sound-code width, the "no tone" code, the bit positions of
// the one-hot grant vector, and a helper that maps a state to its grant.
// ---------------------------------------------------------------------------
package sound_arb_pkg;

   localparam int SOUND_W = 13;

   localparam logic [SOUND_W-1:0] SILENCE = 13'd0;

   // Bit positions inside the one-hot grant vector {alarm, click, lull}
   localparam int GNT_ALARM = 2;
   localparam int GNT_CLICK = 1;
   localparam int GNT_LULL  = 0;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GAP        = 3'd1,
      PLAY_ALARM = 3'd2,
      PLAY_CLICK = 3'd3,
      PLAY_LULL  = 3'd4
   } arb_state_t;

   // One-hot owner for a state; IDLE and GAP own nothing
   function automatic logic [2:0] grant_of(input arb_state_t st);
      logic [2:0] g;
      g = 3'b000;
      case (st)
         PLAY_ALARM: g[GNT_ALARM] = 1'b1;
         PLAY_CLICK: g[GNT_CLICK] = 1'b1;
         PLAY_LULL:  g[GNT_LULL]  = 1'b1;
         default:    g = 3'b000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/arb_timer.sv
// ---------------------------------------------------------------------------
// arb_timer
// Loadable down counter shared by the gap and click phases of the arbiter.
// It stops at zero instead of wrapping; "expired" is high while the count
// is zero, i.e. during the last cycle of a loaded interval.
// Ports:
//   clock      - system clock
//   reset      - synchronous active-high reset (count returns to 0)
//   load       - load load_value this cycle (wins over counting)
//   load_value - value loaded (interval length minus one)
//   expired    - count is zero
// ---------------------------------------------------------------------------
module arb_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] count_r;

   // Count register: load, else decrement until it rests at zero
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (count_r != {W{1'b0}}) begin
         count_r <= count_r - W'(1'b1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == {W{1'b0}});

endmodule

// File: rtl/sound_arbiter.sv
// ---------------------------------------------------------------------------
// sound_arbiter
// Shares one piezo tone generator between the alarm melody, the keypad
// click and the sleep lullaby. Priority is alarm > click > lullaby, and a
// silent gap of GAP_CYCLES is inserted whenever ownership changes hands
// between two sources (never when starting from idle).
//
// Optional feature macro: SOUND_ARBITER_CLICK_EN
//   defined   - keypad click path is present
//   undefined - click_pulse is ignored, grant[1] is always 0, and the
//               arbitration is alarm > lullaby only
//
// Ports:
//   clock        - system clock
//   reset        - synchronous active-high reset
//   alarm_req    - level request from the alarm path
//   alarm_sound  - alarm beat code
//   lull_req     - level request from the lullaby path
//   lull_sound   - lullaby beat code
//   click_pulse  - single-cycle key-press pulse
//   playSound    - registered code driven to the piezo
//   grant        - registered one-hot owner {alarm, click, lull}
//   busy         - registered, high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module sound_arbiter
   import sound_arb_pkg::*;
#(
   parameter int unsigned        CLICK_CYCLES = 32'd2500000,
   parameter int unsigned        GAP_CYCLES   = 32'd50000,
   parameter logic [SOUND_W-1:0] CLICK_SOUND  = 13'd1,
   parameter logic [SOUND_W-1:0] SILENCE      = sound_arb_pkg::SILENCE
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               alarm_req,
   input  logic [SOUND_W-1:0] alarm_sound,
   input  logic               lull_req,
   input  logic [SOUND_W-1:0] lull_sound,
   input  logic               click_pulse,
   output logic [SOUND_W-1:0] playSound,
   output logic [2:0]         grant,
   output logic               busy
);

   localparam int unsigned MAX_CYCLES = (CLICK_CYCLES > GAP_CYCLES) ? CLICK_CYCLES : GAP_CYCLES;
   localparam int TIMER_W = (MAX_CYCLES > 32'd1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 32'd1);

`ifdef SOUND_ARBITER_CLICK_EN
   localparam logic [TIMER_W-1:0] CLICK_LOAD = TIMER_W'(CLICK_CYCLES - 32'd1);
   localparam logic [2:0]         GRANT_MASK = 3'b111;
`else
   localparam logic [2:0]         GRANT_MASK = 3'b101;
`endif

   arb_state_t         state_r;
   arb_state_t         next_s;
   logic               click_req_s;
   logic               timer_load_s;
   logic [TIMER_W-1:0] timer_value_s;
   logic               timer_expired_s;
   logic [SOUND_W-1:0] play_next_s;
   logic [SOUND_W-1:0] play_r;
   logic [2:0]         grant_r;
   logic               busy_r;

   // Highest-priority requester, or IDLE when nobody asks
   function automatic arb_state_t pick_owner(input logic a, input logic c, input logic l);
      arb_state_t s;
      if (a) begin
         s = PLAY_ALARM;
      end else if (c) begin
         s = PLAY_CLICK;
      end else if (l) begin
         s = PLAY_LULL;
      end else begin
         s = IDLE;
      end
      return s;
   endfunction

`ifdef SOUND_ARBITER_CLICK_EN
   logic pend_r;
   logic click_acc_s;

   // A pulse is accepted unless a click is already playing or the alarm
   // claims this cycle; an accepted pulse counts as a request immediately.
   assign click_acc_s = click_pulse & ~alarm_req & (state_r != PLAY_CLICK);
   assign click_req_s = pend_r | click_acc_s;

   // Pending click flag: collapses repeated pulses, cleared when the click starts
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_r <= 1'b0;
      end else if (next_s == PLAY_CLICK) begin
         pend_r <= 1'b0;
      end else if (click_acc_s) begin
         pend_r <= 1'b1;
      end else begin
         pend_r <= pend_r;
      end
   end
`else
   logic unused_click_s;

   assign click_req_s    = 1'b0;
   assign unused_click_s = click_pulse ^ (^CLICK_SOUND);
`endif

   // Next-state arbitration
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            next_s = pick_owner(alarm_req, click_req_s, lull_req);
         end
         GAP: begin
            // Requests are only looked at in the final gap cycle
            if (timer_expired_s) begin
               next_s = pick_owner(alarm_req, click_req_s, lull_req);
            end else begin
               next_s = GAP;
            end
         end
         PLAY_ALARM: begin
            if (alarm_req) begin
               next_s = PLAY_ALARM;
            end else if (click_req_s || lull_req) begin
               next_s = GAP;
            end else begin
               next_s = IDLE;
            end
         end
`ifdef SOUND_ARBITER_CLICK_EN
         PLAY_CLICK: begin
            if (alarm_req) begin
               next_s = GAP;
            end else if (timer_expired_s) begin
               next_s = lull_req ? GAP : IDLE;
            end else begin
               next_s = PLAY_CLICK;
            end
         end
`endif
         PLAY_LULL: begin
            if (alarm_req || click_req_s) begin
               next_s = GAP;
            end else if (!lull_req) begin
               next_s = IDLE;
            end else begin
               next_s = PLAY_LULL;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // Timer reload on entry into a timed phase
   always_comb begin
      timer_load_s  = 1'b0;
      timer_value_s = {TIMER_W{1'b0}};
      if ((next_s == GAP) && (state_r != GAP)) begin
         timer_load_s  = 1'b1;
         timer_value_s = GAP_LOAD;
      end
`ifdef SOUND_ARBITER_CLICK_EN
      else if ((next_s == PLAY_CLICK) && (state_r != PLAY_CLICK)) begin
         timer_load_s  = 1'b1;
         timer_value_s = CLICK_LOAD;
      end
`endif
      else begin
         timer_load_s  = 1'b0;
         timer_value_s = {TIMER_W{1'b0}};
      end
   end

   arb_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load_s),
      .load_value (timer_value_s),
      .expired    (timer_expired_s)
   );

   // Next piezo code: a beat source is forwarded one cycle late, so the
   // first cycle of a new owner is still silent; the click is a constant.
   always_comb begin
      play_next_s = SILENCE;
      case (next_s)
         PLAY_ALARM: play_next_s = (state_r == PLAY_ALARM) ? alarm_sound : SILENCE;
         PLAY_LULL:  play_next_s = (state_r == PLAY_LULL) ? lull_sound : SILENCE;
`ifdef SOUND_ARBITER_CLICK_EN
         PLAY_CLICK: play_next_s = CLICK_SOUND;
`endif
         default:    play_next_s = SILENCE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         play_r  <= SILENCE;
         grant_r <= 3'b000;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         play_r  <= play_next_s;
         grant_r <= grant_of(next_s) & GRANT_MASK;
         busy_r  <= (next_s != IDLE);
      end
   end

   assign playSound = play_r;
   assign grant     = grant_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_sound_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sound_arbiter
// Directed bench for sound_arbiter with short click/gap lengths. A
// cycle-level model of the arbitration rules (owner, remaining phase
// length, pending click) predicts every output and is compared on each
// falling edge; directed sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_sound_arbiter;

   localparam int unsigned CC = 4;
   localparam int unsigned GC = 3;
`ifdef SOUND_ARBITER_CLICK_EN
   localparam bit CLICK_EN = 1'b1;
`else
   localparam bit CLICK_EN = 1'b0;
`endif

   // Model owner codes
   localparam int O_IDLE  = 0;
   localparam int O_ALARM = 1;
   localparam int O_CLICK = 2;
   localparam int O_LULL  = 3;
   localparam int O_GAP   = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        alarm_req;
   logic [12:0] alarm_sound;
   logic        lull_req;
   logic [12:0] lull_sound;
   logic        click_pulse;
   logic [12:0] playSound;
   logic [2:0]  grant;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   int          m_owner = O_IDLE;
   int          m_left  = 0;
   bit          m_pend  = 1'b0;
   logic [12:0] m_play  = 13'd0;
   logic [2:0]  m_grant = 3'b000;
   logic        m_busy  = 1'b0;

   always #5 clock = ~clock;

   sound_arbiter #(
      .CLICK_CYCLES (CC),
      .GAP_CYCLES   (GC),
      .CLICK_SOUND  (13'd1),
      .SILENCE      (13'd0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .alarm_req   (alarm_req),
      .alarm_sound (alarm_sound),
      .lull_req    (lull_req),
      .lull_sound  (lull_sound),
      .click_pulse (click_pulse),
      .playSound   (playSound),
      .grant       (grant),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   function automatic int pick(input bit a, input bit c, input bit l);
      if (a) return O_ALARM;
      else if (c) return O_CLICK;
      else if (l) return O_LULL;
      else return O_IDLE;
   endfunction

   // Reference model: who owns the piezo after this edge and what it hears
   always @(posedge clock) begin : model
      automatic int nxt = O_IDLE;
      automatic bit acc = 1'b0;
      automatic bit creq = 1'b0;
      if (reset) begin
         m_owner <= O_IDLE;
         m_left  <= 0;
         m_pend  <= 1'b0;
         m_play  <= 13'd0;
         m_grant <= 3'b000;
         m_busy  <= 1'b0;
      end else begin
         acc  = CLICK_EN && click_pulse && !alarm_req && (m_owner != O_CLICK);
         creq = m_pend || acc;
         case (m_owner)
            O_IDLE:  nxt = pick(alarm_req, creq, lull_req);
            O_ALARM: nxt = alarm_req ? O_ALARM : ((creq || lull_req) ? O_GAP : O_IDLE);
            O_CLICK: nxt = alarm_req ? O_GAP : ((m_left == 1) ? (lull_req ? O_GAP : O_IDLE) : O_CLICK);
            O_LULL:  nxt = (alarm_req || creq) ? O_GAP : (lull_req ? O_LULL : O_IDLE);
            O_GAP:   nxt = (m_left == 1) ? pick(alarm_req, creq, lull_req) : O_GAP;
            default: nxt = O_IDLE;
         endcase
         if (nxt != m_owner)
            m_left <= (nxt == O_GAP) ? int'(GC) : ((nxt == O_CLICK) ? int'(CC) : 0);
         else
            m_left <= (m_left > 0) ? m_left - 1 : 0;
         m_pend  <= (nxt == O_CLICK) ? 1'b0 : (acc ? 1'b1 : m_pend);
         m_owner <= nxt;
         if (nxt == O_ALARM && m_owner == O_ALARM)     m_play <= alarm_sound;
         else if (nxt == O_LULL && m_owner == O_LULL)  m_play <= lull_sound;
         else if (nxt == O_CLICK)                      m_play <= 13'd1;
         else                                          m_play <= 13'd0;
         case (nxt)
            O_ALARM: m_grant <= 3'b100;
            O_CLICK: m_grant <= 3'b010;
            O_LULL:  m_grant <= 3'b001;
            default: m_grant <= 3'b000;
         endcase
         m_busy <= (nxt != O_IDLE);
      end
   end

   // Compare DUT against the model every cycle once reset has been seen
   always @(negedge clock) begin
      if (chk_en) begin
         chk("model_play", 32'(playSound), 32'(m_play));
         chk("model_grant", 32'(grant), 32'(m_grant));
         chk("model_busy", 32'(busy), 32'(m_busy));
      end
   end

   initial begin
      reset = 1'b1; alarm_req = 1'b0; lull_req = 1'b0; click_pulse = 1'b0;
      alarm_sound = 13'd0; lull_sound = 13'd0;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("reset_play", 32'(playSound), 32'd0);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Lullaby from idle: no gap, sound one cycle after the grant
      lull_req = 1'b1; lull_sound = 13'd5;
      cyc();
      chk("lull_grant", 32'(grant), 32'b001);
      chk("lull_busy", 32'(busy), 32'd1);
      chk("lull_first_silent", 32'(playSound), 32'd0);
      cyc();
      chk("lull_play", 32'(playSound), 32'd5);

      // Alarm preempts lullaby through a gap of exactly GC cycles
      alarm_req = 1'b1; alarm_sound = 13'd9;
      for (int i = 0; i < int'(GC); i++) begin
         cyc();
         chk("gap_grant", 32'(grant), 32'd0);
         chk("gap_play", 32'(playSound), 32'd0);
      end
      cyc();
      chk("alarm_grant", 32'(grant), 32'b100);
      chk("alarm_first_silent", 32'(playSound), 32'd0);
      cyc();
      chk("alarm_play", 32'(playSound), 32'd9);

      // Alarm ends, lullaby still requested: gap then lullaby resumes
      alarm_req = 1'b0;
      repeat (GC) cyc();
      chk("resume_gap_grant", 32'(grant), 32'd0);
      cyc();
      chk("resume_lull_grant", 32'(grant), 32'b001);
      cyc();
      chk("resume_lull_play", 32'(playSound), 32'd5);
      lull_req = 1'b0;
      cyc();
      chk("lull_end_busy", 32'(busy), 32'd0);

      // Reset in the middle of a gap
      lull_req = 1'b1;
      cyc();
      alarm_req = 1'b1;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      chk("rst_gap_play", 32'(playSound), 32'd0);
      chk("rst_gap_grant", 32'(grant), 32'd0);
      chk("rst_gap_busy", 32'(busy), 32'd0);
      reset = 1'b0; lull_req = 1'b0;
      cyc();
      chk("post_rst_alarm", 32'(grant), 32'b100);
      cyc();
      cyc();
      // Reset in the middle of an alarm
      reset = 1'b1;
      cyc();
      chk("rst_alarm_play", 32'(playSound), 32'd0);
      chk("rst_alarm_grant", 32'(grant), 32'd0);
      chk("rst_alarm_busy", 32'(busy), 32'd0);
      reset = 1'b0; alarm_req = 1'b0; lull_req = 1'b1; lull_sound = 13'd7;
      cyc();
      chk("rst_lull_nogap", 32'(grant), 32'b001);
      cyc();
      chk("rst_lull_play", 32'(playSound), 32'd7);

      // Key press while the lullaby plays
      click_pulse = 1'b1;
      cyc();
      click_pulse = 1'b0;
`ifdef SOUND_ARBITER_CLICK_EN
      chk("click_preempts_lull", 32'(grant), 32'd0);
`else
      chk("click_ignored_grant", 32'(grant), 32'b001);
      cyc();
      chk("click_ignored_play", 32'(playSound), 32'd7);
`endif
      lull_req = 1'b0;
      repeat (12) cyc();
      chk("settled_idle", 32'(busy), 32'd0);

`ifdef SOUND_ARBITER_CLICK_EN
      // Click from idle lasts CC cycles; a second pulse inside is dropped
      click_pulse = 1'b1;
      cyc();
      click_pulse = 1'b0;
      for (int i = 0; i < int'(CC); i++) begin
         chk("click_grant", 32'(grant), 32'b010);
         chk("click_play", 32'(playSound), 32'd1);
         if (i == 1) click_pulse = 1'b1;
         else click_pulse = 1'b0;
         if (i < int'(CC) - 1) cyc();
      end
      click_pulse = 1'b0;
      cyc();
      chk("click_end_play", 32'(playSound), 32'd0);
      chk("click_end_busy", 32'(busy), 32'd0);
      repeat (3) begin
         cyc();
         chk("no_extra_click", 32'(grant), 32'd0);
      end

      // Click together with a rising alarm: alarm wins, click is lost
      alarm_req = 1'b1; click_pulse = 1'b1;
      cyc();
      click_pulse = 1'b0;
      chk("simul_alarm", 32'(grant), 32'b100);
      repeat (3) cyc();
      alarm_req = 1'b0;
      repeat (6) begin
         cyc();
         chk("simul_click_dropped", 32'(grant), 32'd0);
      end
`endif

      // Mixed traffic, checked by the model only
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) alarm_req = ~alarm_req;
         if ($urandom_range(0, 5) == 0) lull_req = ~lull_req;
         click_pulse = ($urandom_range(0, 11) == 0);
         alarm_sound = 13'($urandom_range(0, 8191));
         lull_sound  = 13'($urandom_range(0, 8191));
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         else reset = 1'b0;
         cyc();
      end
      reset = 1'b0; alarm_req = 1'b0; lull_req = 1'b0; click_pulse = 1'b0;
      repeat (15) cyc();
      chk("final_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
